// File: rtl/datapath_bus.sv
// Single-bus CPU datapath: one combinational bus driven by the highest-priority
// selected source, loaded into strobed registers on the rising clock edge.
module datapath_bus #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             MDRRead,
   input  logic             ALUen,
   input  logic             incPC,
   input  logic             BAOut,
   input  logic             R0out,
   input  logic             R1out,
   input  logic             R2out,
   input  logic             R3out,
   input  logic             R4out,
   input  logic             R5out,
   input  logic             R6out,
   input  logic             R7out,
   input  logic             R8out,
   input  logic             R9out,
   input  logic             R10out,
   input  logic             R11out,
   input  logic             R12out,
   input  logic             R13out,
   input  logic             R14out,
   input  logic             R20out,
   input  logic             HIout,
   input  logic             LOout,
   input  logic             ZHIout,
   input  logic             ZLOout,
   input  logic             PCout,
   input  logic             MDRout,
   input  logic             InportOut,
   input  logic             Cout,
   input  logic             r0ins,
   input  logic             r1ins,
   input  logic             r2ins,
   input  logic             r3ins,
   input  logic             r4ins,
   input  logic             r5ins,
   input  logic             r6ins,
   input  logic             r7ins,
   input  logic             r8ins,
   input  logic             r9ins,
   input  logic             r10ins,
   input  logic             r11ins,
   input  logic             r12ins,
   input  logic             r13ins,
   input  logic             r14ins,
   input  logic             r20ins,
   input  logic             HIins,
   input  logic             LOins,
   input  logic             ZHIins,
   input  logic             ZLOins,
   input  logic             PCins,
   input  logic             MDRins,
   input  logic             MARins,
   input  logic             IRins,
   input  logic             Inports,
   input  logic             Outports,
   input  logic [WIDTH-1:0] MDRMDataIn,
   output logic [WIDTH-1:0] OutportOut
);

   logic [15:0]      gpr_out;
   logic [15:0]      gpr_ins;
   logic [WIDTH-1:0] gpr_q [16];
   logic [WIDTH-1:0] hi_q, lo_q, zhi_q, zlo_q, pc_q, ir_q, mar_q, mdr_q;
   logic [WIDTH-1:0] inport_q, outport_q;
   logic [WIDTH-1:0] bus;
   logic [WIDTH-1:0] c_sext;
   logic [WIDTH-1:0] zlo_d, mdr_d;

   // R20out/r20ins address the sixteenth GPR (R15)
   assign gpr_out = {R20out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
   assign gpr_ins = {r20ins, r14ins, r13ins, r12ins, r11ins, r10ins, r9ins, r8ins,
                     r7ins, r6ins, r5ins, r4ins, r3ins, r2ins, r1ins, r0ins};

   assign c_sext = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};

   // Assigned lowest priority first so the highest-priority select is written last
   always_comb begin
      bus = '0;
      if (Cout)      bus = c_sext;
      if (InportOut) bus = inport_q;
      if (MDRout)    bus = mdr_q;
      if (PCout)     bus = pc_q;
      if (ZLOout)    bus = zlo_q;
      if (ZHIout)    bus = zhi_q;
      if (LOout)     bus = lo_q;
      if (HIout)     bus = hi_q;
      for (int i = 15; i >= 1; i--) begin
         if (gpr_out[i]) bus = gpr_q[i];
      end
      if (R0out)     bus = gpr_q[0];
      if (BAOut)     bus = '0;
   end

   assign zlo_d = incPC ? bus + WIDTH'(1) : bus;
   assign mdr_d = MDRRead ? MDRMDataIn : bus;

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 16; i++) gpr_q[i] <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         zhi_q     <= '0;
         zlo_q     <= '0;
         pc_q      <= '0;
         ir_q      <= '0;
         mar_q     <= '0;
         mdr_q     <= '0;
         inport_q  <= '0;
         outport_q <= '0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (gpr_ins[i]) gpr_q[i] <= bus;
         end
         if (HIins)           hi_q      <= bus;
         if (LOins)           lo_q      <= bus;
         if (ZHIins && ALUen) zhi_q     <= bus;
         if (ZLOins && ALUen) zlo_q     <= zlo_d;
         if (PCins)           pc_q      <= bus;
         if (IRins)           ir_q      <= bus;
         if (MARins)          mar_q     <= bus;
         if (MDRins)          mdr_q     <= mdr_d;
         if (Inports)         inport_q  <= MDRMDataIn;
         if (Outports)        outport_q <= bus;
      end
   end

   assign OutportOut = outport_q;

endmodule

// File: tb/tb_datapath_bus.sv
// Directed scenarios followed by randomized transfers checked against a
// register-file model of the bus datapath, observed through the output port.
module tb_datapath_bus;

   localparam int unsigned W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic clr, MDRRead, ALUen, incPC, BAOut;
   logic [15:0] r_out, r_ins;
   logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, InportOut, Cout;
   logic HIins, LOins, ZHIins, ZLOins, PCins, MDRins, MARins, IRins;
   logic Inports, Outports;
   logic [W-1:0] din;
   logic [W-1:0] OutportOut;

   int checks = 0;
   int errors = 0;

   // Reference state: plain values per architectural register
   logic [W-1:0] m_gpr [16];
   logic [W-1:0] m_hi, m_lo, m_zhi, m_zlo, m_pc, m_ir, m_mar, m_mdr, m_in, m_out;

   datapath_bus #(.WIDTH(W)) dut (
      .clk(clk), .clr(clr), .MDRRead(MDRRead), .ALUen(ALUen), .incPC(incPC),
      .BAOut(BAOut),
      .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
      .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
      .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
      .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R20out(r_out[15]),
      .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
      .MDRout(MDRout), .InportOut(InportOut), .Cout(Cout),
      .r0ins(r_ins[0]), .r1ins(r_ins[1]), .r2ins(r_ins[2]), .r3ins(r_ins[3]),
      .r4ins(r_ins[4]), .r5ins(r_ins[5]), .r6ins(r_ins[6]), .r7ins(r_ins[7]),
      .r8ins(r_ins[8]), .r9ins(r_ins[9]), .r10ins(r_ins[10]), .r11ins(r_ins[11]),
      .r12ins(r_ins[12]), .r13ins(r_ins[13]), .r14ins(r_ins[14]), .r20ins(r_ins[15]),
      .HIins(HIins), .LOins(LOins), .ZHIins(ZHIins), .ZLOins(ZLOins), .PCins(PCins),
      .MDRins(MDRins), .MARins(MARins), .IRins(IRins),
      .Inports(Inports), .Outports(Outports),
      .MDRMDataIn(din), .OutportOut(OutportOut)
   );

   task automatic idle();
      clr = 0; MDRRead = 0; ALUen = 0; incPC = 0; BAOut = 0;
      r_out = '0; r_ins = '0;
      HIout = 0; LOout = 0; ZHIout = 0; ZLOout = 0; PCout = 0; MDRout = 0;
      InportOut = 0; Cout = 0;
      HIins = 0; LOins = 0; ZHIins = 0; ZLOins = 0; PCins = 0; MDRins = 0;
      MARins = 0; IRins = 0; Inports = 0; Outports = 0;
   endtask

   // Bus value: first enabled source in the priority list wins
   function automatic logic [W-1:0] model_bus();
      logic          en  [28];
      logic [W-1:0]  val [28];
      logic [W-1:0]  ir_c;
      int n = 0;
      ir_c = m_ir;
      en[n] = BAOut; val[n] = '0; n++;
      for (int i = 0; i < 16; i++) begin
         en[n] = r_out[i]; val[n] = m_gpr[i]; n++;
      end
      en[n] = HIout;     val[n] = m_hi;  n++;
      en[n] = LOout;     val[n] = m_lo;  n++;
      en[n] = ZHIout;    val[n] = m_zhi; n++;
      en[n] = ZLOout;    val[n] = m_zlo; n++;
      en[n] = PCout;     val[n] = m_pc;  n++;
      en[n] = MDRout;    val[n] = m_mdr; n++;
      en[n] = InportOut; val[n] = m_in;  n++;
      en[n] = Cout;
      val[n] = (ir_c[18] ? 32'hFFF8_0000 : 32'h0) | (ir_c & 32'h0007_FFFF);
      n++;
      for (int k = 0; k < n; k++) if (en[k]) return val[k];
      return '0;
   endfunction

   task automatic model_edge();
      logic [W-1:0] b;
      if (clr) begin
         for (int i = 0; i < 16; i++) m_gpr[i] = '0;
         m_hi = 0; m_lo = 0; m_zhi = 0; m_zlo = 0; m_pc = 0; m_ir = 0;
         m_mar = 0; m_mdr = 0; m_in = 0; m_out = 0;
         return;
      end
      b = model_bus();
      for (int i = 0; i < 16; i++) if (r_ins[i]) m_gpr[i] = b;
      if (HIins)           m_hi  = b;
      if (LOins)           m_lo  = b;
      if (ZHIins && ALUen) m_zhi = b;
      if (ZLOins && ALUen) m_zlo = incPC ? b + 32'd1 : b;
      if (PCins)           m_pc  = b;
      if (IRins)           m_ir  = b;
      if (MARins)          m_mar = b;
      if (MDRins)          m_mdr = MDRRead ? din : b;
      if (Inports)         m_in  = din;
      if (Outports)        m_out = b;
   endtask

   // Apply the currently driven controls for one edge, then return to idle
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic check(input string tag, input logic [W-1:0] exp);
      checks++;
      assert (OutportOut === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, OutportOut, exp);
      end
   endtask

   initial begin
      idle();
      din = '0;
      for (int i = 0; i < 16; i++) m_gpr[i] = 'x;
      @(negedge clk);

      clr = 1; tick();
      check("reset", 32'h0);
      ZLOout = 1; Outports = 1; tick();
      check("reset_zlo", 32'h0);
      Outports = 1; tick();
      check("bus_idle_zero", 32'h0);

      din = 32'h12; Inports = 1; tick();
      InportOut = 1; HIins = 1; tick();
      HIout = 1; ZHIins = 1; ALUen = 1; tick();
      ZHIout = 1; Outports = 1; tick();
      check("hi_zhi_path", 32'h12);

      din = 32'h32; Inports = 1; tick();
      InportOut = 1; LOins = 1; tick();
      LOout = 1; ZLOins = 1; ALUen = 1; tick();
      ZLOout = 1; Outports = 1; tick();
      check("lo_zlo_path", 32'h32);

      din = 32'hFFFF_FFFF; Inports = 1; tick();
      InportOut = 1; r_ins[1] = 1; tick();
      r_out[1] = 1; ZLOins = 1; ALUen = 1; incPC = 1; tick();
      ZLOout = 1; Outports = 1; tick();
      check("zlo_inc_wrap", 32'h0);

      din = 32'h0007_FFFF; MDRRead = 1; MDRins = 1; tick();
      MDRout = 1; IRins = 1; tick();
      Cout = 1; Outports = 1; tick();
      check("c_sext_neg", 32'hFFFF_FFFF);
      din = 32'h0003_FFFF; MDRRead = 1; MDRins = 1; tick();
      MDRout = 1; IRins = 1; tick();
      Cout = 1; Outports = 1; tick();
      check("c_sext_pos", 32'h0003_FFFF);

      din = 32'h55; Inports = 1; tick();
      InportOut = 1; r_ins[0] = 1; tick();
      BAOut = 1; r_out[0] = 1; Outports = 1; tick();
      check("baout_zero", 32'h0);
      r_out[0] = 1; r_out[1] = 1; Outports = 1; tick();
      check("r0_priority", 32'h55);

      din = 32'h99; Inports = 1; tick();
      InportOut = 1; ZLOins = 1; ALUen = 1; tick();
      r_out[0] = 1; ZLOins = 1; ALUen = 0; tick();
      ZLOout = 1; Outports = 1; tick();
      check("aluen_block", 32'h99);

      // Same register drives and loads: ZLO <= ZLO + 1
      ZLOout = 1; ZLOins = 1; ALUen = 1; incPC = 1; tick();
      ZLOout = 1; Outports = 1; tick();
      check("zlo_self_inc", 32'h9A);

      InportOut = 1; Outports = 1; clr = 1; tick();
      check("clr_mid_transfer", 32'h0);
      InportOut = 1; Outports = 1; tick();
      check("clr_clears_inport", 32'h0);

      // Randomized transfers; model tracks every register, port shows the bus
      for (int c = 0; c < 600; c++) begin
         din       = $urandom;
         clr       = ($urandom_range(0, 63) == 0);
         MDRRead   = $urandom_range(0, 1);
         ALUen     = ($urandom_range(0, 3) != 0);
         incPC     = $urandom_range(0, 1);
         BAOut     = ($urandom_range(0, 15) == 0);
         for (int i = 0; i < 16; i++) begin
            r_out[i] = ($urandom_range(0, 15) == 0);
            r_ins[i] = ($urandom_range(0, 5) == 0);
         end
         HIout     = ($urandom_range(0, 9) == 0);
         LOout     = ($urandom_range(0, 9) == 0);
         ZHIout    = ($urandom_range(0, 9) == 0);
         ZLOout    = ($urandom_range(0, 9) == 0);
         PCout     = ($urandom_range(0, 9) == 0);
         MDRout    = ($urandom_range(0, 9) == 0);
         InportOut = ($urandom_range(0, 9) == 0);
         Cout      = ($urandom_range(0, 9) == 0);
         HIins     = ($urandom_range(0, 4) == 0);
         LOins     = ($urandom_range(0, 4) == 0);
         ZHIins    = ($urandom_range(0, 4) == 0);
         ZLOins    = ($urandom_range(0, 4) == 0);
         PCins     = ($urandom_range(0, 4) == 0);
         MDRins    = ($urandom_range(0, 4) == 0);
         MARins    = ($urandom_range(0, 4) == 0);
         IRins     = ($urandom_range(0, 4) == 0);
         Inports   = ($urandom_range(0, 3) == 0);
         Outports  = ($urandom_range(0, 1) == 0);
         tick();
         check("random", m_out);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
